// File: rtl/shift_unit_if.sv
// Handshake and data bundle between the microcode sequencer and shift_unit.
// The sequencer drives the master side; the shift unit is the slave.
interface shift_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] op;
    logic [CNT_W-1:0] cnt;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cy;
    logic             zero;

    modport master (
        output start, mode, op, cnt, cin,
        input  ready, done, result, cy, zero
    );

    modport slave (
        input  start, mode, op, cnt, cin,
        output ready, done, result, cy, zero
    );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit: one 1-bit step per cycle over a WIDTH-bit
// operand with carry, covering the eight CB-prefix shift modes.
module shift_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic       clk,
    input logic       reset,
    shift_unit_if.slave bus
);
    typedef enum logic [2:0] {
        M_RLC  = 3'd0,
        M_RRC  = 3'd1,
        M_RL   = 3'd2,
        M_RR   = 3'd3,
        M_SLA  = 3'd4,
        M_SRA  = 3'd5,
        M_SWAP = 3'd6,
        M_SRL  = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam int H = WIDTH / 2;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cy_q, cy_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_s;
    logic             step_c;
    logic             accept;
    mode_e            mode_in;

    assign mode_in = mode_e'(bus.mode);

    // Single 1-bit step of the latched mode.
    always_comb begin
        step_s = s_q;
        step_c = c_q;
        unique case (mode_q)
            M_RLC: begin
                step_c = s_q[WIDTH-1];
                step_s = {s_q[WIDTH-2:0], s_q[WIDTH-1]};
            end
            M_RRC: begin
                step_c = s_q[0];
                step_s = {s_q[0], s_q[WIDTH-1:1]};
            end
            M_RL: begin
                step_c = s_q[WIDTH-1];
                step_s = {s_q[WIDTH-2:0], c_q};
            end
            M_RR: begin
                step_c = s_q[0];
                step_s = {c_q, s_q[WIDTH-1:1]};
            end
            M_SLA: begin
                step_c = s_q[WIDTH-1];
                step_s = {s_q[WIDTH-2:0], 1'b0};
            end
            M_SRA: begin
                step_c = s_q[0];
                step_s = {s_q[WIDTH-1], s_q[WIDTH-1:1]};
            end
            M_SWAP: begin
                step_c = 1'b0;
                step_s = {s_q[H-1:0], s_q[WIDTH-1:H]};
            end
            M_SRL: begin
                step_c = s_q[0];
                step_s = {1'b0, s_q[WIDTH-1:1]};
            end
            default: begin
                step_c = c_q;
                step_s = s_q;
            end
        endcase
    end

    assign accept = bus.start && (state_q != S_SHIFT);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        s_d     = s_q;
        c_d     = c_q;
        n_d     = n_q;
        res_d   = res_q;
        cy_d    = cy_q;
        zero_d  = zero_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    mode_d = mode_in;
                    s_d    = bus.op;
                    c_d    = bus.cin;
                    n_d    = (mode_in == M_SWAP) ? ONE : bus.cnt;
                    if (n_d == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                s_d = step_s;
                c_d = step_c;
                n_d = n_q - ONE;
                if (n_q == ONE) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results land on the edge that enters DONE so they align with done.
        if (state_d == S_DONE) begin
            res_d  = s_d;
            cy_d   = c_d;
            zero_d = (s_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_RLC;
            s_q     <= '0;
            c_q     <= 1'b0;
            n_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            s_q     <= s_d;
            c_q     <= c_d;
            n_q     <= n_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.ready  = (state_q != S_SHIFT);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = res_q;
    assign bus.cy     = cy_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit at WIDTH=8 and WIDTH=16.
// Expected values are hand-computed from the step definitions.
module tb_shift_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_unit_if #(.WIDTH(8),  .CNT_W(4)) if8 ();
    shift_unit_if #(.WIDTH(16), .CNT_W(4)) if16 ();

    shift_unit #(.WIDTH(8), .CNT_W(4)) u8 (
        .clk   (clk),
        .reset (rst),
        .bus   (if8)
    );

    shift_unit #(.WIDTH(16), .CNT_W(4)) u16 (
        .clk   (clk),
        .reset (rst),
        .bus   (if16)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue8(input logic [2:0] m, input logic [7:0] o,
                          input logic [3:0] n, input logic ci);
        @(negedge clk);
        if8.start = 1'b1;
        if8.mode  = m;
        if8.op    = o;
        if8.cnt   = n;
        if8.cin   = ci;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (if8.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run8(input string tag, input logic [2:0] m,
                        input logic [7:0] o, input logic [3:0] n,
                        input logic ci, input int k,
                        input logic [7:0] er, input logic ecy,
                        input logic ezr);
        int lat;
        issue8(m, o, n, ci);
        if (k > 0) chk({tag, " ready"}, 32'(if8.ready), 32'd0);
        wait8(lat);
        chk({tag, " lat"}, 32'(lat), 32'(k));
        chk({tag, " res"}, 32'(if8.result), 32'(er));
        chk({tag, " cy"}, 32'(if8.cy), 32'(ecy));
        chk({tag, " zero"}, 32'(if8.zero), 32'(ezr));
    endtask

    task automatic run16(input string tag, input logic [2:0] m,
                         input logic [15:0] o, input logic [3:0] n,
                         input int k, input logic [15:0] er,
                         input logic ecy);
        int lat;
        @(negedge clk);
        if16.start = 1'b1;
        if16.mode  = m;
        if16.op    = o;
        if16.cnt   = n;
        if16.cin   = 1'b0;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        lat = 0;
        while (if16.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " lat"}, 32'(lat), 32'(k));
        chk({tag, " res"}, 32'(if16.result), 32'(er));
        chk({tag, " cy"}, 32'(if16.cy), 32'(ecy));
    endtask

    initial begin
        int lat;
        int hits;
        rst = 1'b1;
        if8.start = 1'b0;
        if8.mode = 3'd0;
        if8.op = '0;
        if8.cnt = '0;
        if8.cin = 1'b0;
        if16.start = 1'b0;
        if16.mode = 3'd0;
        if16.op = '0;
        if16.cnt = '0;
        if16.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", 32'(if8.ready), 32'd1);
        chk("rst done", 32'(if8.done), 32'd0);
        chk("rst res", 32'(if8.result), 32'd0);
        chk("rst cy", 32'(if8.cy), 32'd0);
        chk("rst zero", 32'(if8.zero), 32'd1);
        rst = 1'b0;

        run8("srl1",  3'd7, 8'h81, 4'd1, 1'b0, 1, 8'h40, 1'b1, 1'b0);
        run8("sra3",  3'd5, 8'h80, 4'd3, 1'b0, 3, 8'hF0, 1'b0, 1'b0);
        run8("rr1",   3'd3, 8'h01, 4'd1, 1'b1, 1, 8'h80, 1'b1, 1'b0);
        run8("rl9",   3'd2, 8'h00, 4'd9, 1'b1, 9, 8'h00, 1'b1, 1'b1);
        run8("swap",  3'd6, 8'hA5, 4'd7, 1'b1, 1, 8'h5A, 1'b0, 1'b0);
        run8("sla0",  3'd4, 8'h00, 4'd0, 1'b1, 0, 8'h00, 1'b1, 1'b1);
        run8("rlc1",  3'd0, 8'h81, 4'd1, 1'b0, 1, 8'h03, 1'b1, 1'b0);
        run8("rrc2",  3'd1, 8'h01, 4'd2, 1'b0, 2, 8'h40, 1'b0, 1'b0);
        run8("sla1",  3'd4, 8'hC0, 4'd1, 1'b0, 1, 8'h80, 1'b1, 1'b0);
        run8("srl8",  3'd7, 8'hFF, 4'd8, 1'b0, 8, 8'h00, 1'b1, 1'b1);
        run8("sra15", 3'd5, 8'h80, 4'd15, 1'b0, 15, 8'hFF, 1'b1, 1'b0);

        // Back-to-back: second request issued during the first DONE cycle.
        run8("b2b a", 3'd4, 8'h01, 4'd2, 1'b0, 2, 8'h04, 1'b0, 1'b0);
        run8("b2b b", 3'd7, 8'h04, 4'd2, 1'b0, 2, 8'h01, 1'b0, 1'b0);

        // Start while busy must be dropped.
        issue8(3'd7, 8'hF0, 4'd5, 1'b0);
        @(posedge clk);
        #1;
        if8.start = 1'b1;
        if8.mode = 3'd0;
        if8.op = 8'h3C;
        if8.cnt = 4'd1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        wait8(lat);
        chk("ign lat", 32'(lat + 2), 32'd5);
        chk("ign res", 32'(if8.result), 32'h07);
        chk("ign cy", 32'(if8.cy), 32'd1);
        @(posedge clk);
        #1;
        chk("ign nodone", 32'(if8.done), 32'd0);

        // Reset mid-shift aborts the request.
        issue8(3'd7, 8'hFF, 4'd5, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort ready", 32'(if8.ready), 32'd1);
        chk("abort done", 32'(if8.done), 32'd0);
        chk("abort res", 32'(if8.result), 32'd0);
        chk("abort cy", 32'(if8.cy), 32'd0);
        chk("abort zero", 32'(if8.zero), 32'd1);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (if8.done === 1'b1) hits++;
        end
        chk("abort quiet", 32'(hits), 32'd0);

        run16("w16 rlc",  3'd0, 16'h8001, 4'd1, 1, 16'h0003, 1'b1);
        run16("w16 swap", 3'd6, 16'h12AB, 4'd3, 1, 16'hAB12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_unit.md
# shift_unit

Sequential, parametrised shift/rotate unit for the CPU ALU. It generalises the single-cycle 8-bit shift path to any even `WIDTH` and all eight CB-prefix shift modes. It supports a multi-bit shift count executed one bit per cycle, with carry-in/carry-out and a zero flag. It sits beside the ALU core and is started by the microcode sequencer with a start/ready/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width; must be even and at least 2.
- `CNT_W`, default 4: width of the shift-count input.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `mode`  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL.
- `op`  in  WIDTH  operand, sampled on accept.
- `cnt`  in  CNT_W  number of 1-bit steps, sampled on accept; ignored for SWAP.
- `cin`  in  1  initial carry, sampled on accept.
- `ready`  out  1  unit can accept `start`.
- `done`  out  1  one-cycle pulse; `result`, `cy` and `zero` are valid from this cycle.
- `result`  out  WIDTH  shifted value; held until the next completion.
- `cy`  out  1  carry flag after the last step; held.
- `zero`  out  1  `result` == 0; held.

## Operation
- States: IDLE, SHIFT, DONE.
  - `ready`=1 in IDLE and DONE, 0 in SHIFT.
  - `start` while `ready`=0 is ignored and not queued.
- Accepting a request:
  - On accept, latch `op` into working register `s`, `cin` into working carry `c`, and `mode`.
  - Load the step counter `n` with `cnt`. For SWAP, `n` is forced to 1.
  - If `n`=0, go directly to DONE. Otherwise go to SHIFT.
- SHIFT: each cycle performs one step and decrements `n`. After the step that brings `n` to 0, go to DONE.
- DONE:
  - Copy `s` to `result` and `c` to `cy`, set `zero` = (`s`==0), and pulse `done`.
  - Next state is IDLE, or a new accept if `start`=1 (back-to-back accepted).
- Step definitions, with W = `WIDTH`:
  - RLC: c=s[W-1]; s={s[W-2:0],s[W-1]}
  - RRC: c=s[0]; s={s[0],s[W-1:1]}
  - RL: c=s[W-1]; s={s[W-2:0],c_old}
  - RR: c=s[0]; s={c_old,s[W-1:1]}
  - SLA: c=s[W-1]; s={s[W-2:0],1'b0}
  - SRA: c=s[0]; s={s[W-1],s[W-1:1]}
  - SRL: c=s[0]; s={1'b0,s[W-1:1]}
  - SWAP: s={s[W/2-1:0],s[W-1:W/2]}; c=0
- Counts of W or more are legal and not saturated.
  - RL/RR form a (W+1)-bit ring.
  - SLA/SRL reach 0 after W steps.
  - SRA reaches all sign bits after W steps.
- cnt=0 (non-SWAP): `result`=`op`, `cy`=`cin`, no shift.

## Timing
- Accept at cycle T (`start`=1 and `ready`=1 at the edge).
- `done`=1 during cycle T+k+1, where k = `cnt` (non-SWAP), 1 (SWAP), or 0 (`cnt`=0).
- The outputs update on the same edge that raises `done`, so they are valid in that cycle.
- Outputs change only at completion and are stable between completions.
- Throughput: a new accept is possible in the DONE cycle, so the next `done` can follow at T'+k'+1.
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, `cy`=0, `zero`=1; internal `s`, `c` and `n` are cleared.
- `reset` has priority over `start` in the same cycle.
- Reset mid-operation aborts at the next edge: no `done` for the aborted request, and the outputs go to their reset values.

## Test plan
- SRL, WIDTH=8, op=0x81, cnt=1, accept at T -> `done` at T+2, `result`=0x40, `cy`=1, `zero`=0; `ready`=0 at T+1.
- SRA, op=0x80, cnt=3 -> `done` at T+4, `result`=0xF0, `cy`=0. Also RR, op=0x01, cin=1, cnt=1 -> 0x80, `cy`=1.
- RL, op=0x00, cin=1, cnt=9 (full 9-bit ring) -> `result`=0x00, `cy`=1, `zero`=1, `done` at T+10.
- SWAP, op=0xA5, cnt=7 -> `done` at T+2, `result`=0x5A, `cy`=0. Also SLA, cnt=0, op=0x00, cin=1 -> `done` at T+1, `result`=0x00, `cy`=1, `zero`=1.
- Handshake:
  - SRL with cnt=5; pulse `start` with different operands at T+2 -> ignored, original result delivered at T+6.
  - New `start` during the DONE cycle -> accepted back-to-back.
- Reset: `reset`=1 at T+2 of an SRL cnt=5 request -> no `done` pulse, `ready`=1, `result`=0, `cy`=0, `zero`=1 from T+3.
- WIDTH=16 build: RLC, op=0x8001, cnt=1 -> 0x0003, `cy`=1. SWAP, op=0x12AB -> 0xAB12.
